// File: rtl/histo_readout.sv
// -----------------------------------------------------------------------------
// histo_readout
//
// Reader side of the trigger board's monitoring-histogram interface. A start
// request walks histostosend through bin indices 0..NBINS-1. For each index the
// block waits for the histosout path to settle, then snapshots the 256-bit
// record into a shadow register. It streams the record as 33 bytes: the index
// byte, then words 0..7 LSB-first. A header byte opens the frame. resethist is
// optionally pulsed after the last record.
//
// Ports
//   clk          in   1    system clock, rising edge
//   nrst         in   1    asynchronous active-low reset
//   start        in   1    1-cycle readout request, ignored while busy
//   clear_after  in   1    sampled with start: pulse resethist after the frame
//   histostosend out  8    bin index presented to the histogram block
//   histosin     in   256  histosout flattened, word w = bits [32w+31:32w]
//   tx_data      out  8    byte to serializer
//   tx_valid     out  1    tx_data valid
//   tx_ready     in   1    serializer accepts when tx_valid && tx_ready
//   resethist    out  1    1-cycle histogram clear request
//   busy         out  1    frame in progress
//   done         out  1    1-cycle pulse at frame (and clear) completion
// -----------------------------------------------------------------------------
module histo_readout #(
    parameter int         NBINS  = 16,
    parameter int         SETTLE = 4,
    parameter logic [7:0] HDR    = 8'hA5
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         start,
    input  logic         clear_after,
    output logic [7:0]   histostosend,
    input  logic [255:0] histosin,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         resethist,
    output logic         busy,
    output logic         done
);

    localparam int         CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [7:0] LAST_IDX = 8'(NBINS - 1);
    localparam logic [5:0] LAST_BYTE = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SETTLE,
        S_CAP,
        S_SEND,
        S_CLR,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [5:0]         bcnt_q;
    logic [255:0]       shadow_q;
    logic               clr_q;
    logic [4:0]         bsel;

    assign histostosend = idx_q;

    // Byte k (1..32) of a record is shadow byte k-1; only meaningful for bcnt_q>0.
    assign bsel = 5'(bcnt_q - 6'd1);

    // Next state and outputs; every output is decoded from registered state so
    // tx_data/tx_valid stay stable while the serializer stalls.
    always_comb begin
        state_d   = state_q;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        resethist = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_HDR;
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR;
                if (tx_ready) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_CAP;
            end
            S_CAP: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = (bcnt_q == 6'd0) ? idx_q : shadow_q[{bsel, 3'b000} +: 8];
                if (tx_ready && bcnt_q == LAST_BYTE) begin
                    if (idx_q == LAST_IDX) state_d = clr_q ? S_CLR : S_FIN;
                    else                   state_d = S_SETTLE;
                end
            end
            S_CLR: begin
                resethist = 1'b1;
                state_d   = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                busy    = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            idx_q    <= 8'h00;
            cnt_q    <= '0;
            bcnt_q   <= 6'd0;
            shadow_q <= '0;
            clr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        clr_q <= clear_after;
                        idx_q <= 8'h00;
                    end
                end
                S_HDR: begin
                    if (tx_ready) cnt_q <= CNT_W'(SETTLE - 1);
                end
                S_SETTLE: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                S_CAP: begin
                    // Snapshot decouples serializer stalls from histogram updates.
                    shadow_q <= histosin;
                    bcnt_q   <= 6'd0;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (bcnt_q == LAST_BYTE) begin
                            bcnt_q <= 6'd0;
                            // Index stays at NBINS-1 after the last record.
                            if (idx_q != LAST_IDX) begin
                                idx_q <= idx_q + 8'd1;
                                cnt_q <= CNT_W'(SETTLE - 1);
                            end
                        end else begin
                            bcnt_q <= bcnt_q + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_histo_readout.sv
module tb_histo_readout;

    logic         clk = 1'b0;
    logic         nrst;
    logic         start, clear_after, tx_ready;
    logic [7:0]   hts, tx_data;
    logic [255:0] histosin;
    logic         tx_valid, resethist, busy, done;

    logic         start_1, tx_ready_1;
    logic [7:0]   hts_1, tx_data_1;
    logic [255:0] histosin_1;
    logic         tx_valid_1, resethist_1, busy_1, done_1;

    logic [7:0]   p1 = 8'h00, p2 = 8'h00, p1b = 8'h00, p2b = 8'h00;
    logic [7:0]   noise_q = 8'h00;
    logic         noise_en = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    histo_readout u_dut (
        .clk(clk), .nrst(nrst), .start(start), .clear_after(clear_after),
        .histostosend(hts), .histosin(histosin), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .resethist(resethist),
        .busy(busy), .done(done)
    );

    histo_readout #(.NBINS(1), .SETTLE(1)) u_dut1 (
        .clk(clk), .nrst(nrst), .start(start_1), .clear_after(1'b0),
        .histostosend(hts_1), .histosin(histosin_1), .tx_data(tx_data_1),
        .tx_valid(tx_valid_1), .tx_ready(tx_ready_1), .resethist(resethist_1),
        .busy(busy_1), .done(done_1)
    );

    // Histogram block model: 2-stage registered path from index to data.
    function automatic logic [255:0] pattern(input logic [7:0] i);
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[32*w +: 32] = 32'h100 * w + {24'h0, i};
        return v;
    endfunction

    always @(posedge clk) begin
        p1      <= hts;
        p2      <= p1;
        p1b     <= hts_1;
        p2b     <= p1b;
        noise_q <= noise_q + 8'h5B;
    end

    // Noise is only injected while bytes are offered, i.e. after capture.
    always_comb begin
        histosin   = pattern(p2);
        if (noise_en && tx_valid) histosin = histosin ^ {32{noise_q}};
        histosin_1 = pattern(p2b);
    end

    function automatic logic [7:0] exp_byte(input int n);
        int r, b, w, bi;
        logic [31:0] word;
        if (n == 0) return 8'hA5;
        r = (n - 1) / 33;
        b = (n - 1) % 33;
        if (b == 0) return 8'(r);
        w  = (b - 1) / 4;
        bi = (b - 1) % 4;
        word = 32'h100 * w + r;
        return word[8*bi +: 8];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tx_valid"},  tx_valid,  0);
        chk({tag, "_tx_data"},   tx_data,   0);
        chk({tag, "_resethist"}, resethist, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_hts"},       hts,       0);
    endtask

    task automatic run_frame(input bit clr, input int pct, input bit nz,
                             input int dup_at, input int rst_at);
        int   nb = 0, cyc = 0, rh = 0, rh_at = -1, done_at = -1, last_hs = -1;
        bit   prev_stall = 0, dup_done = 0, aborted = 0;
        logic [7:0] prev_data = 8'h00;
        noise_en = nz;
        @(negedge clk);
        clear_after = clr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear_after = 1'b0;
        chk("busy_after_start", busy, 1);
        while (cyc < 20000) begin
            if (prev_stall) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, prev_data);
            end
            chk("idx_range", hts <= 8'd15, 1);
            if (resethist) begin
                rh++;
                rh_at = nb;
            end
            if (done) begin
                done_at = cyc;
                chk("done_latency", cyc - last_hs, clr ? 2 : 1);
                break;
            end
            start = 1'b0;
            if (dup_at >= 0 && nb == dup_at && !dup_done) begin
                start = 1'b1;
                dup_done = 1;
            end
            if (rst_at >= 0 && nb == rst_at) begin
                start = 1'b0;
                tx_ready = 1'b0;
                nrst = 1'b0;
                #1;
                chk_outputs_zero("async_rst");
                aborted = 1;
                break;
            end
            tx_ready = ($urandom_range(99) < pct);
            if (tx_valid && tx_ready) begin
                chk("byte", {nb[15:0], tx_data}, {nb[15:0], exp_byte(nb)});
                nb++;
                last_hs = cyc;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b0;
        start = 1'b0;
        noise_en = 1'b0;
        if (aborted) begin
            repeat (3) begin
                @(negedge clk);
                chk("rst_hold_resethist", resethist, 0);
                chk("rst_hold_busy", busy, 0);
            end
            chk("abort_no_clear", rh, 0);
            nrst = 1'b1;
            @(negedge clk);
        end else begin
            chk("done_seen", done_at >= 0, 1);
            chk("frame_len", nb, 529);
            chk("resethist_count", rh, clr ? 1 : 0);
            if (clr) chk("resethist_pos", rh_at, 529);
            repeat (5) begin
                @(negedge clk);
                chk("post_busy", busy, 0);
                chk("post_done", done, 0);
                chk("post_valid", tx_valid, 0);
            end
        end
    endtask

    task automatic run_small();
        int nb = 0;
        bit seen_done = 0;
        @(negedge clk);
        start_1 = 1'b1;
        tx_ready_1 = 1'b1;
        @(negedge clk);
        start_1 = 1'b0;
        for (int c = 0; c < 500; c++) begin
            chk("small_hts", hts_1, 0);
            if (done_1) begin
                seen_done = 1;
                break;
            end
            if (tx_valid_1) begin
                chk("small_byte", {nb[15:0], tx_data_1}, {nb[15:0], exp_byte(nb)});
                nb++;
            end
            @(negedge clk);
        end
        tx_ready_1 = 1'b0;
        chk("small_done", seen_done, 1);
        chk("small_len", nb, 34);
        chk("small_resethist", resethist_1, 0);
    endtask

    initial begin
        nrst = 1'b0;
        start = 1'b0;
        clear_after = 1'b0;
        tx_ready = 1'b0;
        start_1 = 1'b0;
        tx_ready_1 = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        chk("reset_dut1_busy", busy_1, 0);
        chk("reset_dut1_valid", tx_valid_1, 0);
        nrst = 1'b1;

        // tx_ready alone does nothing while idle
        tx_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid", tx_valid, 0);
            chk("idle_busy", busy, 0);
        end
        tx_ready = 1'b0;

        run_frame(0, 100, 0, -1, -1);   // plain frame
        run_frame(0, 100, 1, -1, -1);   // histosin changes during SEND
        run_frame(0, 50,  1, -1, -1);   // back-pressure
        run_frame(1, 100, 0, -1, -1);   // clear after frame
        run_frame(0, 100, 0, 100, -1);  // start while busy not queued
        run_frame(1, 100, 0, 100, 200); // abort mid-frame, no clear issued
        run_frame(0, 100, 0, -1, -1);   // clean frame after abort
        run_small();                    // NBINS=1, SETTLE=1 build

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
